conv_row_feeder: RTL

Producer side of the convolution data-preprocess lanes. Reads packed feature-map columns from line SRAM, one word per cycle. Each word holds SA_Units vertically adjacent pixels. The block streams them, zero-padded left and right, onto the lane bus that feeds the per-lane sliding-window shifters. It drives the window-reset/run strobe (out_start) per row band, so the shifters restart cleanly at every band.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_feeder_addr_gen.sv | 69 ++++++
 rtl/conv_row_feeder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types, defaults and helpers for the convolution row feeder.
package conv_pkg;

  // Defaults shared by the feeder and its neighbours in the preprocess path.
  localparam int DEF_KERNEL_SIZE = 32'sd3;
  localparam int DEF_DATA_WIDTH  = 32'sd16;
  localparam int DEF_SA_UNITS    = 32'sd4;

  // Feeder sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  // Zero columns added on each side of a row so the window stays centred.
  function automatic int pad_of(input int kernel_size);
    return (kernel_size - 32'sd1) / 32'sd2;
  endfunction

endpackage

// File: rtl/conv_feeder_addr_gen.sv
// Band/column counters and SRAM read-request generation for the row feeder.
// k walks every column of a band including the pads; only interior columns
// produce a read, addressed as band*width + (k - PAD).
module conv_feeder_addr_gen
  import conv_pkg::*;
#(
  parameter int PAD        = 1,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 10
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  logic                  i_next_band,
  input  logic                  i_stream,
  input  logic [DIM_WIDTH-1:0]  i_width,
  input  logic [DIM_WIDTH-1:0]  i_num_bands,
  output logic                  o_k_last,
  output logic                  o_band_last,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr
);

  localparam int KW = DIM_WIDTH + 1;
  localparam int PW = 2 * DIM_WIDTH + 1;

  logic [KW-1:0]        r_k;
  logic [DIM_WIDTH-1:0] r_band;

  logic [KW-1:0] w_len;
  logic [KW-1:0] w_data_end;
  logic [KW-1:0] w_col;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_sum;

  // Column counter restarts per band; band counter restarts per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= {KW{1'b0}};
      r_band <= {DIM_WIDTH{1'b0}};
    end else if (i_clear) begin
      r_k    <= {KW{1'b0}};
      r_band <= {DIM_WIDTH{1'b0}};
    end else if (i_next_band) begin
      r_k    <= {KW{1'b0}};
      r_band <= r_band + DIM_WIDTH'(1);
    end else if (i_step) begin
      r_k    <= r_k + KW'(1);
      r_band <= r_band;
    end else begin
      r_k    <= r_k;
      r_band <= r_band;
    end
  end

  assign w_len      = {1'b0, i_width} + KW'(2 * PAD);
  assign w_data_end = {1'b0, i_width} + KW'(PAD);
  assign w_col      = r_k - KW'(PAD);
  assign w_prod     = PW'(r_band) * PW'(i_width);
  assign w_sum      = w_prod + PW'(w_col);

  assign o_k_last    = (r_k == (w_len - KW'(1)));
  assign o_band_last = (r_band == (i_num_bands - DIM_WIDTH'(1)));
  assign o_rd_en     = i_stream && (r_k >= KW'(PAD)) && (r_k < w_data_end);
  // Address is forced to zero outside a read so an idle/reset bus is quiet.
  assign o_rd_addr   = o_rd_en ? ADDR_WIDTH'(w_sum) : {ADDR_WIDTH{1'b0}};

endmodule

// File: rtl/conv_row_feeder.sv
// Streams packed SRAM columns, zero-padded left and right, onto the lane bus
// feeding the sliding-window shifters. out_start frames each row band; its low
// cycles between bands clear the shifters.
module conv_row_feeder
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SA_Units    = DEF_SA_UNITS,
  parameter int ADDR_WIDTH  = 12,
  parameter int DIM_WIDTH   = 10,
  parameter int GAP_CYCLES  = 1
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           go,
  input  logic                           abort,
  input  logic [DIM_WIDTH-1:0]           cfg_img_width,
  input  logic [DIM_WIDTH-1:0]           cfg_num_bands,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [DATA_WIDTH*SA_Units-1:0] mem_rd_data,
  output logic [DATA_WIDTH*SA_Units-1:0] out_data,
  output logic                           out_start,
  output logic                           busy,
  output logic                           done
);

  localparam int PAD    = pad_of(KERNEL_SIZE);
  localparam int LANE_W = DATA_WIDTH * SA_Units;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  feeder_state_t        r_state;
  logic [DIM_WIDTH-1:0] r_width;
  logic [DIM_WIDTH-1:0] r_bands;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_drain_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_s1_valid;
  logic                 r_s1_is_data;
  logic                 r_out_start;
  logic [LANE_W-1:0]    r_out_data;

  logic                  w_go_ok;
  logic                  w_degenerate;
  logic                  w_stream;
  logic                  w_step;
  logic                  w_next_band;
  logic                  w_k_last;
  logic                  w_band_last;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // A go is taken only from a truly idle block (the done cycle still counts
  // as busy), and abort always wins.
  assign w_go_ok      = (r_state == IDLE) && go && !r_busy && !abort;
  assign w_degenerate = (cfg_img_width == {DIM_WIDTH{1'b0}}) ||
                        (cfg_num_bands == {DIM_WIDTH{1'b0}});
  assign w_stream     = (r_state == STREAM);
  assign w_step       = w_stream && !abort;
  assign w_next_band  = (r_state == GAP) && (r_gap_cnt == GAP_LAST) && !abort;

  conv_feeder_addr_gen #(
    .PAD        (PAD),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (reset),
    .i_clear     (w_go_ok),
    .i_step      (w_step),
    .i_next_band (w_next_band),
    .i_stream    (w_stream),
    .i_width     (r_width),
    .i_num_bands (r_bands),
    .o_k_last    (w_k_last),
    .o_band_last (w_band_last),
    .o_rd_en     (w_rd_en),
    .o_rd_addr   (w_rd_addr)
  );

  // Frame sequencer: config latch, band/gap/drain sequencing, busy and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_width     <= {DIM_WIDTH{1'b0}};
      r_bands     <= {DIM_WIDTH{1'b0}};
      r_gap_cnt   <= {GAP_W{1'b0}};
      r_drain_cnt <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_gap_cnt   <= {GAP_W{1'b0}};
      r_drain_cnt <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go_ok) begin
            r_width     <= cfg_img_width;
            r_bands     <= cfg_num_bands;
            r_busy      <= 1'b1;
            r_drain_cnt <= 1'b0;
            r_state     <= w_degenerate ? DRAIN : STREAM;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        STREAM: begin
          if (w_k_last) begin
            if (w_band_last) begin
              r_drain_cnt <= 1'b0;
              r_state     <= DRAIN;
            end else begin
              r_gap_cnt <= {GAP_W{1'b0}};
              r_state   <= GAP;
            end
          end else begin
            r_state <= STREAM;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= STREAM;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Two-stage output pipeline: stage 1 lines up with the SRAM read latency,
  // stage 2 muxes SRAM data against zero pads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_is_data <= 1'b0;
      r_out_start  <= 1'b0;
      r_out_data   <= {LANE_W{1'b0}};
    end else if (abort) begin
      r_s1_valid   <= 1'b0;
      r_s1_is_data <= 1'b0;
      r_out_start  <= 1'b0;
      r_out_data   <= {LANE_W{1'b0}};
    end else begin
      r_s1_valid   <= w_stream;
      r_s1_is_data <= w_rd_en;
      r_out_start  <= r_s1_valid;
      r_out_data   <= r_s1_is_data ? mem_rd_data : {LANE_W{1'b0}};
    end
  end

  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = w_rd_addr;
  assign out_data    = r_out_data;
  assign out_start   = r_out_start;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
